tx_packet_router: RTL and testbench
===================================

// Module: tx_packet_router
// PURPOSE
//  Routes 32-bit inband TX packets from the USB packer to per-channel packet RAMs (data channels + command channel).
//  - Sits between the USB word packer (usbdata_final/WR_final) and the channel_ram instances of the TX buffer.
//  - Decodes the channel field of each header and checks target space at header time.
//  - Streams all PKT_WORDS words of the packet into the target RAM, or drops the whole packet and counts the drop.
// PARAMETERS
//  NUM_CHAN   2    number of data channels; command channel is index NUM_CHAN
//  PKT_WORDS  128  32-bit words per packet (512 bytes), header included
//  CMD_CHAN   31   header channel code for the command channel (5'h1F)
// PORTS
//  txclk            in   1           sole clock
//  reset            in   1           synchronous, active-high
//  usbdata_final    in   32          packed word from USB packer
//  WR_final         in   1           usbdata_final valid this cycle
//  chan_have_space  in   NUM_CHAN+1  per-RAM "can accept one full packet"
//  clear_status     in   1           clears drop_count and bad_chan_count
//  WR_channel       out  NUM_CHAN+1  one-hot write strobe, aligned with ram_data
//  WR_done_channel  out  NUM_CHAN+1  one-cycle pulse with last word of packet
//  ram_data         out  32          registered copy of routed word
//  drop_count       out  16          packets dropped for lack of space, saturating
//  bad_chan_count   out  16          packets dropped for unknown channel, saturating
//  debug            out  8           {state[1:0], target[2:0], word_cnt[2:0]}
// BEHAVIOUR
//  - Reset: WR_channel=0, WR_done_channel=0, ram_data=0, counters=0, state=IDLE, word_cnt=0.
//  - Header fields: chan=word[20:16], payload_len=word[8:0]; payload_len is not used for routing.
//  - Packets are always exactly PKT_WORDS words, so word_cnt alone sets boundaries.
//  - States:
//    - IDLE: on WR_final, the word is a header.
//      - chan<NUM_CHAN -> target=chan; chan==CMD_CHAN -> target=NUM_CHAN; else -> DROP and bad_chan_count++.
//      - If target valid but chan_have_space[target]==0 -> DROP and drop_count++.
//      - Otherwise -> ROUTE and the header word itself is written.
//      - word_cnt=1 after the header.
//    - ROUTE: each WR_final writes one word to target; word_cnt++.
//      - On word PKT_WORDS-1: WR_done_channel[target] pulses, then -> IDLE.
//    - DROP: consumes words without any write.
//      - On word PKT_WORDS-1 -> IDLE, with no WR_done pulse.
//  - Latency: exactly 1 txclk from WR_final to WR_channel/ram_data.
//    - WR_done_channel pulses in the same cycle as the final WR_channel.
//  - Cycles without WR_final: no strobes, state and count held; arbitrary gaps are allowed.
//  - chan_have_space is sampled only at the header; deassertion mid-packet does not abort the packet.
//  - Counters saturate at 16'hFFFF.
//    - clear_status zeroes both counters; an increment in the same cycle is lost (clear wins).
//  - Reset mid-packet: the partial packet is abandoned with no WR_done, and the next WR_final word is taken as a header.
//    - The downstream RAM is reset by the same reset.
//  - Never more than one WR_channel bit is high; WR_done_channel is a subset of WR_channel.
// STRUCTURE
//  - Shared include tx_inband_defs.vh: PKT_WORDS, CMD_CHAN, header field bit positions (CHAN_HI/LO, LEN_HI/LO), state encodings.
//  - One sub-module, pkt_word_counter: 7-bit counter with inc/clear, emitting a last-word flag at PKT_WORDS-1.
//  - Routing FSM, output registers and counters stay in tx_packet_router.
// TESTING
//  1. Header chan=0, space=3'b111, 128 back-to-back words
//     -> WR_channel=3'b001 for 128 cycles, 1 cycle late; WR_done_channel[0] only on word 128; ram_data matches input.
//  2. Header chan=5'h1F, 128 words with random WR_final gaps
//     -> only WR_channel[2] strobes (128 total), WR_done_channel[2] once; no strobes in gap cycles.
//  3. Header chan=1 with chan_have_space[1]=0
//     -> no strobes for 128 words, drop_count=1; next packet chan=1 with space=1 is routed normally.
//  4. Header chan=5 -> no strobes, bad_chan_count=1; the following packet's header is decoded correctly.
//  5. Reset asserted at word 60 of a chan=0 packet
//     -> outputs 0 next cycle, no WR_done; next word decoded as header (chan=1) and routed to WR_channel[1].
//  6. Force drop_count to 16'hFFFF and drop one more -> stays 16'hFFFF.
//     Then clear_status in the same cycle as a drop increment -> 0.

Source files
------------

// File: rtl/tx_packet_router_pkg.sv
// Shared definitions for the TX inband packet router: packet geometry,
// header field positions, FSM state encoding and header field helpers.
package tx_packet_router_pkg;

  localparam int unsigned PKT_WORDS = 128;
  localparam int unsigned CNT_W     = 7;
  localparam logic [4:0]  CMD_CHAN  = 5'h1F;

  localparam int unsigned CHAN_HI = 20;
  localparam int unsigned CHAN_LO = 16;
  localparam int unsigned LEN_HI  = 8;
  localparam int unsigned LEN_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  function automatic logic [4:0] hdr_chan(input logic [31:0] word);
    return word[CHAN_HI:CHAN_LO];
  endfunction

  function automatic logic [8:0] hdr_len(input logic [31:0] word);
    return word[LEN_HI:LEN_LO];
  endfunction

endpackage

// File: rtl/tx_packet_router_if.sv
// Packer-to-RAM bus of the TX router: incoming packed words, per-RAM
// space flags, and the routed write strobes/data towards the channel RAMs.
interface tx_packet_router_if #(
  parameter int NUM_CHAN = 2
);
  logic [31:0]     usbdata_final;
  logic            WR_final;
  logic [NUM_CHAN:0] chan_have_space;
  logic [NUM_CHAN:0] WR_channel;
  logic [NUM_CHAN:0] WR_done_channel;
  logic [31:0]     ram_data;

  modport master (
    output usbdata_final, WR_final, chan_have_space,
    input  WR_channel, WR_done_channel, ram_data
  );

  modport slave (
    input  usbdata_final, WR_final, chan_have_space,
    output WR_channel, WR_done_channel, ram_data
  );
endinterface

// File: rtl/tx_packet_router_pkt_word_counter.sv
// Word position within the current packet; flags the final word.
module pkt_word_counter
  import tx_packet_router_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // clear takes priority so the final word wraps the count back to zero
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CNT_W'(PKT_WORDS - 1));

endmodule

// File: rtl/tx_packet_router.sv
// Routes fixed-length inband TX packets to per-channel packet RAMs, or
// drops whole packets on unknown channel / no space and counts the drops.
module tx_packet_router
  import tx_packet_router_pkg::*;
#(
  parameter int NUM_CHAN = 2
) (
  input  logic                 txclk,
  input  logic                 reset,
  tx_packet_router_if.slave    bus,
  input  logic                 clear_status,
  output logic [15:0]          drop_count,
  output logic [15:0]          bad_chan_count,
  output logic [7:0]           debug
);

  localparam int W = NUM_CHAN + 1;

  state_t           state_q, state_d;
  logic [2:0]       target_q, target_d;
  logic [W-1:0]     wr_q, wr_d, done_q, done_d;
  logic [31:0]      data_q, data_d;
  logic [15:0]      drop_cnt_q, bad_cnt_q;
  logic             inc_drop, inc_bad;
  logic [CNT_W-1:0] word_cnt;
  logic             last_word;
  logic             cnt_clear;

  logic [4:0]       chan;
  logic             chan_data, chan_ok;
  logic [2:0]       hdr_target;
  logic             hdr_space;

  assign chan       = hdr_chan(bus.usbdata_final);
  assign chan_data  = (chan < 5'(NUM_CHAN));
  assign chan_ok    = chan_data || (chan == CMD_CHAN);
  assign hdr_target = chan_data ? chan[2:0] : 3'(NUM_CHAN);
  assign hdr_space  = |((W'(1) << hdr_target) & bus.chan_have_space);

  // Counter is idle at zero in IDLE, so the header itself brings it to 1
  assign cnt_clear = bus.WR_final && last_word && (state_q != ST_IDLE);

  pkt_word_counter u_word_cnt (
    .clk   (txclk),
    .rst   (reset),
    .inc   (bus.WR_final),
    .clear (cnt_clear),
    .count (word_cnt),
    .last  (last_word)
  );

  // State, target and registered RAM-side outputs
  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      wr_q     <= '0;
      done_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  // Header decode, routing decision and next-cycle strobes
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    wr_d     = '0;
    done_d   = '0;
    data_d   = data_q;
    inc_drop = 1'b0;
    inc_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.WR_final) begin
          if (!chan_ok) begin
            state_d = ST_DROP;
            inc_bad = 1'b1;
          end else if (!hdr_space) begin
            state_d  = ST_DROP;
            inc_drop = 1'b1;
          end else begin
            state_d  = ST_ROUTE;
            target_d = hdr_target;
            wr_d     = W'(1) << hdr_target;
            data_d   = bus.usbdata_final;
          end
        end
      end
      ST_ROUTE: begin
        if (bus.WR_final) begin
          wr_d   = W'(1) << target_q;
          data_d = bus.usbdata_final;
          if (last_word) begin
            done_d  = W'(1) << target_q;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (bus.WR_final && last_word) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating drop counters; clear_status beats a same-cycle increment
  always_ff @(posedge txclk) begin
    if (reset || clear_status) begin
      drop_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      if (inc_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (inc_bad && (bad_cnt_q != '1))   bad_cnt_q  <= bad_cnt_q + 1'b1;
    end
  end

  assign bus.WR_channel      = wr_q;
  assign bus.WR_done_channel = done_q;
  assign bus.ram_data        = data_q;
  assign drop_count          = drop_cnt_q;
  assign bad_chan_count      = bad_cnt_q;
  assign debug               = {state_q, target_q, word_cnt[2:0]};

endmodule

// File: tb/tb_tx_packet_router.sv
// Directed bench for tx_packet_router: routing, gaps, drops, reset, counters.
module tb_tx_packet_router;

  localparam int PKT = 128;

  logic        txclk = 1'b0;
  logic        reset;
  logic        clear_status;
  logic [15:0] drop_count;
  logic [15:0] bad_chan_count;
  logic [7:0]  debug;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int dones    = 0;

  tx_packet_router_if #(.NUM_CHAN(2)) bus ();

  tx_packet_router #(.NUM_CHAN(2)) dut (
    .txclk          (txclk),
    .reset          (reset),
    .bus            (bus.slave),
    .clear_status   (clear_status),
    .drop_count     (drop_count),
    .bad_chan_count (bad_chan_count),
    .debug          (debug)
  );

  always #5 txclk = ~txclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pkt_word(input logic [4:0] chan, input int i);
    logic [31:0] w;
    if (i == 0) w = {11'h0, chan, 7'h0, 9'd508};
    else        w = {8'hC3, 3'b0, chan, i[15:0]};
    return w;
  endfunction

  task automatic idle_cycle(input string tag);
    @(negedge txclk);
    bus.WR_final      = 1'b0;
    bus.usbdata_final = '0;
    @(posedge txclk);
    #1;
    check_val({tag, "_gap_wr"}, 32'(bus.WR_channel), 32'd0);
    check_val({tag, "_gap_done"}, 32'(bus.WR_done_channel), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] exp_wr,
                           input logic [2:0] exp_done, input string tag);
    @(negedge txclk);
    bus.WR_final      = 1'b1;
    bus.usbdata_final = d;
    @(posedge txclk);
    #1;
    check_val({tag, "_wr"}, 32'(bus.WR_channel), 32'(exp_wr));
    check_val({tag, "_done"}, 32'(bus.WR_done_channel), 32'(exp_done));
    if (exp_wr != 3'b000) check_val({tag, "_data"}, bus.ram_data, d);
    if (bus.WR_channel != 3'b000) strobes++;
    if (bus.WR_done_channel != 3'b000) dones++;
  endtask

  task automatic send_pkt(input logic [4:0] chan, input logic [2:0] exp_wr,
                          input int first, input int last, input int gap_mod,
                          input string tag);
    for (int i = first; i <= last; i++) begin
      if (gap_mod > 0 && (i % gap_mod) == gap_mod - 1) idle_cycle(tag);
      send_word(pkt_word(chan, i), exp_wr, (i == PKT - 1) ? exp_wr : 3'b000, tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.WR_final        = 1'b0;
    bus.usbdata_final   = '0;
    bus.chan_have_space = 3'b111;
    clear_status        = 1'b0;
    reset               = 1'b1;
    repeat (2) @(posedge txclk);
    #1;
    check_val("rst_wr", 32'(bus.WR_channel), 32'd0);
    check_val("rst_done", 32'(bus.WR_done_channel), 32'd0);
    check_val("rst_data", bus.ram_data, 32'd0);
    check_val("rst_drop", 32'(drop_count), 32'd0);
    check_val("rst_bad", 32'(bad_chan_count), 32'd0);
    check_val("rst_debug", 32'(debug), 32'd0);
    @(negedge txclk);
    reset = 1'b0;

    // 1: chan 0, back-to-back
    strobes = 0; dones = 0;
    send_pkt(5'd0, 3'b001, 0, 0, 0, "t1");
    check_val("t1_debug_hdr", 32'(debug), 32'h41);
    send_pkt(5'd0, 3'b001, 1, PKT - 1, 0, "t1");
    idle_cycle("t1");
    check_val("t1_strobes", strobes, PKT);
    check_val("t1_dones", dones, 1);
    check_val("t1_debug_end", 32'(debug), 32'h00);

    // 2: command channel with gaps
    strobes = 0; dones = 0;
    send_pkt(5'h1F, 3'b100, 0, PKT - 1, 4, "t2");
    idle_cycle("t2");
    check_val("t2_strobes", strobes, PKT);
    check_val("t2_dones", dones, 1);

    // 3: no space on chan 1, then routed; space drop mid-packet ignored
    bus.chan_have_space = 3'b101;
    send_pkt(5'd1, 3'b000, 0, PKT - 1, 0, "t3d");
    idle_cycle("t3d");
    check_val("t3_drop", 32'(drop_count), 32'd1);
    check_val("t3_bad", 32'(bad_chan_count), 32'd0);
    bus.chan_have_space = 3'b111;
    strobes = 0; dones = 0;
    send_pkt(5'd1, 3'b010, 0, 49, 0, "t3r");
    bus.chan_have_space = 3'b000;
    send_pkt(5'd1, 3'b010, 50, PKT - 1, 0, "t3r");
    idle_cycle("t3r");
    bus.chan_have_space = 3'b111;
    check_val("t3_strobes", strobes, PKT);
    check_val("t3_dones", dones, 1);

    // 4: unknown channel, then a good header
    send_pkt(5'd5, 3'b000, 0, PKT - 1, 0, "t4d");
    idle_cycle("t4d");
    check_val("t4_bad", 32'(bad_chan_count), 32'd1);
    check_val("t4_drop", 32'(drop_count), 32'd1);
    send_pkt(5'd0, 3'b001, 0, PKT - 1, 0, "t4r");
    idle_cycle("t4r");

    // 5: reset at word 60
    send_pkt(5'd0, 3'b001, 0, 59, 0, "t5a");
    @(negedge txclk);
    reset             = 1'b1;
    bus.WR_final      = 1'b1;
    bus.usbdata_final = pkt_word(5'd0, 60);
    @(posedge txclk);
    #1;
    check_val("t5_rst_wr", 32'(bus.WR_channel), 32'd0);
    check_val("t5_rst_done", 32'(bus.WR_done_channel), 32'd0);
    check_val("t5_rst_data", bus.ram_data, 32'd0);
    check_val("t5_rst_debug", 32'(debug), 32'd0);
    check_val("t5_rst_drop", 32'(drop_count), 32'd0);
    @(negedge txclk);
    reset        = 1'b0;
    bus.WR_final = 1'b0;
    strobes = 0; dones = 0;
    send_pkt(5'd1, 3'b010, 0, PKT - 1, 0, "t5b");
    idle_cycle("t5b");
    check_val("t5_strobes", strobes, PKT);
    check_val("t5_dones", dones, 1);

    // 6: saturation and clear priority
    @(negedge txclk);
    force dut.drop_cnt_q = 16'hFFFF;
    @(negedge txclk);
    release dut.drop_cnt_q;
    check_val("t6_forced", 32'(drop_count), 32'hFFFF);
    bus.chan_have_space = 3'b110;
    send_pkt(5'd0, 3'b000, 0, PKT - 1, 0, "t6s");
    idle_cycle("t6s");
    check_val("t6_sat", 32'(drop_count), 32'hFFFF);
    clear_status = 1'b1;
    send_word(pkt_word(5'd0, 0), 3'b000, 3'b000, "t6c");
    clear_status = 1'b0;
    send_pkt(5'd0, 3'b000, 1, PKT - 1, 0, "t6c");
    idle_cycle("t6c");
    check_val("t6_clear_sat", 32'(drop_count), 32'd0);
    send_pkt(5'd0, 3'b000, 0, PKT - 1, 0, "t6n");
    idle_cycle("t6n");
    check_val("t6_one", 32'(drop_count), 32'd1);
    clear_status = 1'b1;
    send_word(pkt_word(5'd0, 0), 3'b000, 3'b000, "t6k");
    clear_status = 1'b0;
    send_pkt(5'd0, 3'b000, 1, PKT - 1, 0, "t6k");
    idle_cycle("t6k");
    check_val("t6_clear_wins", 32'(drop_count), 32'd0);
    bus.chan_have_space = 3'b111;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
